pc_sequencer: RTL

- Control FSM that sequences the program counter.
- Each cycle it takes decode-stage requests (branch, multi-cycle memory op, halt) and drives the PC's Branch, target and Done inputs.
- Holds a programmable branch-target lookup table (LUT) and a saturating cycle counter for performance reporting.
- Sits between the instruction decoder and the PC; its Start is shared with the PC.

---
 rtl/pc_ctrl_pkg.sv | 20 ++
 rtl/pc_sequencer_if.sv | 34 +++
 rtl/branch_lut.sv | 27 ++
 rtl/pc_sequencer.sv | 97 +++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types and default sizing for the program-counter sequencer slice.
package pc_ctrl_pkg;

  localparam int D_DEF       = 12;
  localparam int L_DEF       = 4;
  localparam int MEM_LAT_DEF = 2;
  localparam int CW_DEF      = 16;

  // Stall counter only needs to cover MEM_LAT-1 with MEM_LAT <= 15.
  localparam int SCW = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } state_t;

  typedef logic [L_DEF-1:0] lut_idx_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder/config/PC-side signal bundle for pc_sequencer; slave is the sequencer side.
interface pc_sequencer_if
  import pc_ctrl_pkg::*;
#(
  parameter int D  = D_DEF,
  parameter int L  = L_DEF,
  parameter int CW = CW_DEF
);

  logic          BrReq;
  logic          Cond;
  logic [L-1:0]  JmpIdx;
  logic          MemReq;
  logic          HaltReq;
  logic          CfgWe;
  logic [L-1:0]  CfgAddr;
  logic [D-1:0]  CfgData;
  logic          Branch;
  logic [D-1:0]  target;
  logic          Done;
  logic          Finished;
  logic [CW-1:0] CycleCnt;

  modport master (
    output BrReq, Cond, JmpIdx, MemReq, HaltReq, CfgWe, CfgAddr, CfgData,
    input  Branch, target, Done, Finished, CycleCnt
  );

  modport slave (
    input  BrReq, Cond, JmpIdx, MemReq, HaltReq, CfgWe, CfgAddr, CfgData,
    output Branch, target, Done, Finished, CycleCnt
  );

endinterface

// File: rtl/branch_lut.sv
// Branch-target table: 2^L x D registers, one synchronous write port, one combinational read port.
// Not cleared by Start; a write and a read of the same entry in one cycle returns the old value.
module branch_lut
  import pc_ctrl_pkg::*;
#(
  parameter int D = D_DEF,
  parameter int L = L_DEF
) (
  input  logic         clk,
  input  logic         we,
  input  logic [L-1:0] waddr,
  input  logic [D-1:0] wdata,
  input  logic [L-1:0] raddr,
  output logic [D-1:0] rdata
);

  logic [D-1:0] mem [2**L];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pc_sequencer.sv
// PC control FSM (RUN/STALL/HALT): Branch/target/Done are combinational for the PC to sample
// at the same edge; Finished and CycleCnt are registered. Start is the shared sync reset.
module pc_sequencer
  import pc_ctrl_pkg::*;
#(
  parameter int D       = D_DEF,
  parameter int L       = L_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int CW      = CW_DEF
) (
  input  logic           clk,
  input  logic           Start,
  pc_sequencer_if.slave  io
);

  state_t         state;
  logic [SCW-1:0] stall_cnt;
  logic [CW-1:0]  cyc_cnt;
  logic           finished;
  logic [D-1:0]   lut_rd;
  logic           br_taken;

  branch_lut #(
    .D (D),
    .L (L)
  ) u_lut (
    .clk   (clk),
    .we    (io.CfgWe),
    .waddr (io.CfgAddr),
    .wdata (io.CfgData),
    .raddr (io.JmpIdx),
    .rdata (lut_rd)
  );

  assign br_taken = io.BrReq & io.Cond;

  // A zero LUT entry is passed through untouched; the PC treats it as fall-through.
  always_comb begin
    io.Branch = 1'b0;
    io.Done   = 1'b0;
    io.target = lut_rd;
    if (Start) begin
      io.target = '0;
    end else begin
      case (state)
        RUN: begin
          if (io.HaltReq || io.MemReq) begin
            io.Done = 1'b1;
          end else begin
            io.Branch = br_taken;
          end
        end
        STALL:   io.Done = (stall_cnt != '0);
        HALT:    io.Done = 1'b1;
        default: io.Done = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Start) begin
      state     <= RUN;
      stall_cnt <= '0;
      finished  <= 1'b0;
      cyc_cnt   <= '0;
    end else begin
      if (state != HALT && cyc_cnt != '1) begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end
      case (state)
        RUN: begin
          if (io.HaltReq) begin
            state    <= HALT;
            finished <= 1'b1;
          end else if (io.MemReq) begin
            state     <= STALL;
            stall_cnt <= SCW'(MEM_LAT - 1);
          end
        end
        STALL: begin
          // Decode inputs are ignored here; the decoder keeps re-presenting the memory op.
          if (stall_cnt != '0) begin
            stall_cnt <= stall_cnt - 1'b1;
          end else begin
            state <= RUN;
          end
        end
        HALT:    finished <= 1'b1;
        default: state    <= RUN;
      endcase
    end
  end

  assign io.Finished = finished;
  assign io.CycleCnt = cyc_cnt;

endmodule
